// File: rtl/store_monitor.sv
// Observes core stores, logs them into a small FIFO and drives a RUN/PASS/FAIL verdict.
// Verdict and log outputs are registered (visible the cycle after the sampled edge); never stalls the core.
module store_monitor #(
    parameter logic [31:0] RESULT_ADDR = 32'd100,
    parameter logic [31:0] PASS_VALUE  = 32'd25,
    parameter int          MEM_BYTES   = 256,
    parameter int          LOG_DEPTH   = 8,
    parameter int          TIMEOUT     = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_code,
    output logic [15:0] store_count,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [1:0]  log_size,
    output logic        log_overflow
);
    localparam int          PW       = $clog2(LOG_DEPTH);
    localparam logic [31:0] LP_MEM   = 32'(MEM_BYTES);
    localparam logic [31:0] LP_TMO   = 32'(TIMEOUT - 1);
    localparam logic [PW:0] LP_DEPTH = (PW + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } log_entry_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_fail_code, w_code_nxt;
    logic [31:0] r_cycles;
    logic [15:0] r_store_count;
    logic        r_overflow;
    log_entry_t  r_mem [LOG_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_cnt;

    logic        w_store, w_misalign, w_oor, w_hit, w_push, w_pop, w_full, w_write;
    logic [31:0] w_mdata;
    log_entry_t  w_head;

    assign w_store    = (MemWrite != 2'b00);
    assign w_misalign = (MemWrite == 2'b10 && DataAdr[0]) ||
                        (MemWrite == 2'b11 && DataAdr[1:0] != 2'b00);
    assign w_oor      = (DataAdr >= LP_MEM);
    assign w_hit      = (DataAdr == RESULT_ADDR);

    always_comb begin
        w_mdata = WriteData;
        case (MemWrite)
            2'b01:   w_mdata = {24'b0, WriteData[7:0]};
            2'b10:   w_mdata = {16'b0, WriteData[15:0]};
            default: w_mdata = WriteData;
        endcase
    end

    // First matching rule wins; a terminating store beats the timeout on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_fail_code;
        if (r_state == ST_RUN) begin
            if (w_store && w_misalign) begin
                w_state_nxt = ST_FAIL;
                w_code_nxt  = 3'd2;
            end else if (w_store && w_oor) begin
                w_state_nxt = ST_FAIL;
                w_code_nxt  = 3'd3;
            end else if (w_store && w_hit && w_mdata == PASS_VALUE) begin
                w_state_nxt = ST_PASS;
            end else if (w_store && w_hit) begin
                w_state_nxt = ST_FAIL;
                w_code_nxt  = 3'd1;
            end else if (r_cycles == LP_TMO) begin
                w_state_nxt = ST_FAIL;
                w_code_nxt  = 3'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_fail_code   <= 3'd0;
            r_cycles      <= 32'd0;
            r_store_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_code <= w_code_nxt;
            if (r_state == ST_RUN)
                r_cycles <= r_cycles + 32'd1;
            if (w_push && r_store_count != 16'hFFFF)
                r_store_count <= r_store_count + 16'd1;
        end
    end

    assign w_push  = w_store && (r_state == ST_RUN);
    assign w_pop   = log_valid && log_ready;
    assign w_full  = (r_cnt == LP_DEPTH);
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_write && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_write && w_pop)
                r_cnt <= r_cnt - 1'b1;
            if (w_push && !w_write)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= '{addr: DataAdr, data: w_mdata, size: MemWrite};
    end

    assign w_head       = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;
    assign log_valid    = (r_cnt != '0);
    assign log_addr     = w_head.addr;
    assign log_data     = w_head.data;
    assign log_size     = w_head.size;
    assign log_overflow = r_overflow;
    assign done         = (r_state != ST_RUN);
    assign pass         = (r_state == ST_PASS);
    assign fail_code    = r_fail_code;
    assign store_count  = r_store_count;
endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: main instance with default timeout, second instance with TIMEOUT=20.
module tb_store_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  MemWrite = 2'b00;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        log_ready = 1'b0;

    logic        done, pass, log_valid, log_overflow;
    logic [2:0]  fail_code;
    logic [15:0] store_count;
    logic [31:0] log_addr, log_data;
    logic [1:0]  log_size;

    logic        t_done, t_pass, t_log_valid, t_log_overflow;
    logic [2:0]  t_fail_code;
    logic [15:0] t_store_count;
    logic [31:0] t_log_addr, t_log_data;
    logic [1:0]  t_log_size;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_monitor dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail_code(fail_code), .store_count(store_count),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
        .log_size(log_size), .log_overflow(log_overflow)
    );

    store_monitor #(.TIMEOUT(20)) dut_tmo (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(t_done), .pass(t_pass), .fail_code(t_fail_code), .store_count(t_store_count),
        .log_valid(t_log_valid), .log_ready(log_ready), .log_addr(t_log_addr), .log_data(t_log_data),
        .log_size(t_log_size), .log_overflow(t_log_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        MemWrite = 2'b00;
        log_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        MemWrite = sz;
        DataAdr = a;
        WriteData = d;
        tick();
        MemWrite = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
        if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0b exp 0", pass); end
        if (fail_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", fail_code); end
        if (store_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", store_count); end
        if (log_valid !== 1'b0) begin n_fail++; $display("FAIL reset_log_valid got %0b exp 0", log_valid); end
        if ({log_addr, log_data, log_size} !== 66'd0) begin n_fail++; $display("FAIL reset_log_fields got %0h exp 0", {log_addr, log_data, log_size}); end
        if (log_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b exp 0", log_overflow); end
    endtask

    task automatic test_pass();
        do_reset();
        store(2'b11, 32'd96, 32'd7);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL pass_early_done got %0b exp 0", done); end
        store(2'b11, 32'd100, 32'd25);
        n_checks += 4;
        if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL pass_verdict got %0b exp 11", {done, pass}); end
        if (fail_code !== 3'd0) begin n_fail++; $display("FAIL pass_code got %0d exp 0", fail_code); end
        if (store_count !== 16'd2) begin n_fail++; $display("FAIL pass_count got %0d exp 2", store_count); end
        if ({log_valid, log_addr, log_data, log_size} !== {1'b1, 32'd96, 32'd7, 2'b11}) begin
            n_fail++; $display("FAIL pass_log0 got %0h/%0h/%0h exp 60/7/3", log_addr, log_data, log_size); end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        n_checks++;
        if ({log_valid, log_addr, log_data, log_size} !== {1'b1, 32'd100, 32'd25, 2'b11}) begin
            n_fail++; $display("FAIL pass_log1 got %0h/%0h/%0h exp 64/19/3", log_addr, log_data, log_size); end
        log_ready = 1'b1;
        tick();
        tick();
        log_ready = 1'b0;
        n_checks++;
        if (log_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drained got %0b exp 0", log_valid); end
    endtask

    task automatic test_mask();
        do_reset();
        store(2'b01, 32'd100, 32'hFFFF_FF19);
        n_checks += 2;
        if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL mask_byte_pass got %0b exp 11", {done, pass}); end
        if ({log_data, log_size} !== {32'h19, 2'b01}) begin n_fail++; $display("FAIL mask_byte_log got %0h/%0h exp 19/1", log_data, log_size); end
        do_reset();
        store(2'b10, 32'd100, 32'hABCD_0019);
        n_checks++;
        if ({log_data, pass} !== {32'h19, 1'b1}) begin n_fail++; $display("FAIL mask_half got %0h/%0b exp 19/1", log_data, pass); end
    endtask

    task automatic test_wrong_value();
        do_reset();
        store(2'b11, 32'd100, 32'd24);
        n_checks++;
        if ({done, pass, fail_code} !== {1'b1, 1'b0, 3'd1}) begin n_fail++; $display("FAIL wrong_verdict got %0b%0b/%0d exp 10/1", done, pass, fail_code); end
        store(2'b11, 32'd100, 32'd25);
        tick();
        n_checks++;
        if ({pass, fail_code, store_count} !== {1'b0, 3'd1, 16'd1}) begin n_fail++; $display("FAIL wrong_ignored got %0b/%0d/%0d exp 0/1/1", pass, fail_code, store_count); end
    endtask

    task automatic test_bad_store();
        do_reset();
        store(2'b10, 32'd98, 32'd5);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL half_aligned_done got %0b exp 0", done); end
        store(2'b11, 32'd102, 32'd5);
        n_checks++;
        if ({done, fail_code, store_count} !== {1'b1, 3'd2, 16'd2}) begin n_fail++; $display("FAIL misalign got %0b/%0d/%0d exp 1/2/2", done, fail_code, store_count); end
        do_reset();
        store(2'b01, 32'd256, 32'd1);
        n_checks++;
        if ({done, fail_code} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL out_of_range got %0b/%0d exp 1/3", done, fail_code); end
        do_reset();
        store(2'b01, 32'd255, 32'd1);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL range_edge got %0b exp 0", done); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) store(2'b11, 32'd0, i);
        n_checks++;
        if ({log_valid, log_overflow, store_count, log_data} !== {1'b1, 1'b1, 16'd9, 32'd0}) begin
            n_fail++; $display("FAIL overflow got v%0b o%0b c%0d d%0h exp v1 o1 c9 d0", log_valid, log_overflow, store_count, log_data); end
        do_reset();
        for (int i = 0; i < 8; i++) store(2'b11, 4 * i, i);
        log_ready = 1'b1;
        store(2'b11, 32'd32, 32'd8);
        log_ready = 1'b0;
        n_checks++;
        if ({log_overflow, store_count, log_addr, log_data} !== {1'b0, 16'd9, 32'd4, 32'd1}) begin
            n_fail++; $display("FAIL full_pop got o%0b c%0d a%0h d%0h exp o0 c9 a4 d1", log_overflow, store_count, log_addr, log_data); end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if ({log_valid, log_addr, log_data} !== {1'b1, 32'(4 * i), 32'(i)}) begin
                n_fail++; $display("FAIL drain_%0d got %0b/%0h/%0h exp 1/%0h/%0h", i, log_valid, log_addr, log_data, 4 * i, i); end
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        n_checks++;
        if (log_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %0b exp 0", log_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (19) tick();
        n_checks++;
        if (t_done !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %0b exp 0", t_done); end
        tick();
        n_checks += 2;
        if ({t_done, t_pass, t_fail_code} !== {1'b1, 1'b0, 3'd4}) begin n_fail++; $display("FAIL tmo_verdict got %0b%0b/%0d exp 10/4", t_done, t_pass, t_fail_code); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_main_running got %0b exp 0", done); end
        do_reset();
        repeat (19) tick();
        store(2'b11, 32'd100, 32'd25);
        n_checks++;
        if ({t_done, t_pass, t_fail_code, t_store_count} !== {1'b1, 1'b1, 3'd0, 16'd1}) begin
            n_fail++; $display("FAIL tmo_store_wins got %0b%0b/%0d/%0d exp 11/0/1", t_done, t_pass, t_fail_code, t_store_count); end
    endtask

    task automatic test_back_to_back_reset();
        do_reset();
        store(2'b11, 32'd0, 32'd1);
        store(2'b11, 32'd4, 32'd2);
        store(2'b11, 32'd8, 32'd3);
        n_checks++;
        if ({log_valid, store_count} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL midrun_pre got %0b/%0d exp 1/3", log_valid, store_count); end
        store(2'b11, 32'd100, 32'd9);
        do_reset();
        n_checks++;
        if ({log_valid, store_count, done, fail_code, log_overflow} !== {1'b0, 16'd0, 1'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL midrun_reset got v%0b c%0d d%0b f%0d o%0b exp all 0", log_valid, store_count, done, fail_code, log_overflow); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mask();
        test_wrong_value();
        test_bad_store();
        test_overflow();
        test_timeout();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
